ras_spec_stack: RTL
===================

Name: ras_spec_stack

Overview:
- Parametrised successor of the fetch-predictor return address stack (RAS).
- Speculative circular return-address stack, updated by the fetch predictor on link/return actions.
- Adds the following over a fixed 16x38 stack:
  - configurable depth and PC width
  - atomic pop-then-push for RET_L
  - saturating occupancy count
  - single-cycle restore of (head, count) from a mispredict/checkpoint
- Sits beside the BTB/GBPT in the fetch predictor; head/count are snapshotted per prediction and restored on redirect.

Parameters:
- RAS_ENTRIES, 16, stack depth; power of two, >= 2.
- LOG_RAS_ENTRIES, $clog2(RAS_ENTRIES), head index width.
- PC_WIDTH, 38, stored return-address width (PC38_t default).

Ports:
- CLK  input  1  clock
- RST  input  1  asynchronous, active-high reset
- link_valid  input  1  push link_pc (JUMP_L / INDIRECT_L / RET_L link half)
- link_pc  input  PC_WIDTH  return address to push
- ret_valid  input  1  pop (RET / RET_L / return half)
- ret_pc  output  PC_WIDTH  array[head]; registered state, valid every cycle
- ret_empty  output  1  count == 0
- ras_head  output  LOG_RAS_ENTRIES  current head, for snapshot
- ras_count  output  LOG_RAS_ENTRIES+1  current occupancy, 0..RAS_ENTRIES
- restore_valid  input  1  restore head/count
- restore_head  input  LOG_RAS_ENTRIES  head to restore
- restore_count  input  LOG_RAS_ENTRIES+1  count to restore; values > RAS_ENTRIES clamp to RAS_ENTRIES
- overflow  output  1  registered pulse: previous cycle's push overwrote a live entry

Behaviour:
- Reset (async, RST=1):
  - head=0, count=0, all array entries=0, overflow=0.
  - ret_pc=0, ret_empty=1, ras_count=0, ras_head=0.
- All state updates on the rising CLK edge; outputs are pure functions of registers (zero combinational path from inputs).
- Priority: restore_valid > (link_valid & ret_valid) > link_valid > ret_valid.
- Restore:
  - head <= restore_head; count <= min(restore_count, RAS_ENTRIES).
  - Array untouched; same-cycle link/ret ignored; overflow <= 0.
- Push only:
  - head <= head+1 mod RAS_ENTRIES; array[head+1] <= link_pc.
  - count <= min(count+1, RAS_ENTRIES); overflow <= (count == RAS_ENTRIES).
- Pop only:
  - head <= head-1 mod RAS_ENTRIES (always moves, even when empty, so mispredicted underflow stays restorable).
  - count <= max(count-1, 0). Array untouched; overflow <= 0.
- Push+pop (RET_L):
  - array[head] <= link_pc; head unchanged.
  - count <= (count == 0) ? 1 : count; overflow <= 0.
- Idle: state held; overflow <= 0.
- Wrap-around: head 15 push -> 0; head 0 pop -> 15 (N=16). Index arithmetic is modulo via natural truncation to LOG_RAS_ENTRIES bits.
- Reset asserted mid-operation: immediate clear; input values while RST=1 are ignored.

Optional Feature:
- Macro: RAS_OVERFLOW_STATS_EN.
- Defined:
  - Adds output overflow_count[15:0], reset 0.
  - Increments (saturating at 16'hFFFF) every cycle the overflow register is set by a push.
  - Cleared only by reset; not affected by restore.
- Undefined: port and counter absent; the overflow pulse still exists.

Decomposition:
- corep package:
  - RAS_ENTRIES, LOG_RAS_ENTRIES, RAS_idx_t, RAS_count_t.
  - New typedef RAS_ptr_t {RAS_idx_t head; RAS_count_t count;}, used for checkpoint snapshot and restore.
- Natural sub-module: ras_spec_stack_array.
  - RAS_ENTRIES x PC_WIDTH register array with one write port, one read port and async reset.
  - Lets the array be swapped for a latch/SRAM macro later.
- Control logic (head/count/overflow) stays in the top.

Test Plan:
- Reset: push A, B, C = 38'h100, 38'h200, 38'h300.
  - Expect head=3, count=3, ret_pc=38'h300.
  - Then 3 pops give ret_pc 38'h200, 38'h100, 0; ret_empty=1 after the third.
- Overflow/wrap: 17 pushes of values 1..17 (N=16).
  - Expect count stays 16, head=1, ret_pc=17, overflow=1 exactly once (cycle after push 17).
  - Then 16 pops return 16..2 then 17.
- RET_L: push 38'hAA, then link+ret same cycle with 38'hBB.
  - Expect head unchanged=1, count=1, ret_pc=38'hBB.
  - From empty with head=0: link+ret with 38'hCC -> count=1, array[0]=38'hCC.
- Restore priority: snapshot head=2, count=2; push X, Y.
  - Assert restore (2,2) in the same cycle as link_valid with Z.
  - Expect head=2, count=2, ret_pc=original entry 2, Z not written.
- Underflow recovery: from head=1, count=1, pop twice.
  - Expect head=15, count=0, ret_empty=1.
  - restore (1,1) -> ret_pc = original entry 1.
- RAS_OVERFLOW_STATS_EN: 20 pushes into N=16 -> overflow_count=4; reset mid-sequence -> 0.

Source files
------------

// File: rtl/ras_spec_stack_pkg.sv
// ras_spec_stack_pkg
//   Shared types for the speculative return address stack.
//   - DEF_* constants give the default geometry (16 entries, 38-bit PC).
//   - RAS_idx_t / RAS_count_t / RAS_ptr_t are the default-geometry head,
//     occupancy and checkpoint types. The fetch predictor snapshots a
//     RAS_ptr_t per prediction and hands it back on a redirect.
//   - ras_op_e names the single operation applied in a cycle once the
//     input priority has been resolved.
package ras_spec_stack_pkg;

  localparam int DEF_RAS_ENTRIES     = 16;
  localparam int DEF_LOG_RAS_ENTRIES = $clog2(DEF_RAS_ENTRIES);
  localparam int DEF_PC_WIDTH        = 38;

  typedef logic [DEF_PC_WIDTH-1:0]        PC38_t;
  typedef logic [DEF_LOG_RAS_ENTRIES-1:0] RAS_idx_t;
  typedef logic [DEF_LOG_RAS_ENTRIES:0]   RAS_count_t;

  typedef struct packed {
    RAS_idx_t   head;
    RAS_count_t count;
  } RAS_ptr_t;

  typedef enum logic [2:0] {
    OP_IDLE     = 3'd0,
    OP_RESTORE  = 3'd1,
    OP_PUSH_POP = 3'd2,
    OP_PUSH     = 3'd3,
    OP_POP      = 3'd4
  } ras_op_e;

  // Priority: restore > push+pop > push > pop > idle.
  function automatic ras_op_e ras_op_decode(input logic restore,
                                            input logic link,
                                            input logic ret);
    ras_op_e op;
    if (restore)          op = OP_RESTORE;
    else if (link && ret) op = OP_PUSH_POP;
    else if (link)        op = OP_PUSH;
    else if (ret)         op = OP_POP;
    else                  op = OP_IDLE;
    return op;
  endfunction

endpackage

// File: rtl/ras_spec_stack_array.sv
// ras_spec_stack_array
//   ENTRIES x DATA_W register file with one write port, one read port and
//   asynchronous clear. Kept separate so it can later be replaced by a
//   latch array or SRAM macro without touching the stack control.
// Ports:
//   clk, rst    clock, async active-high clear of every entry
//   we          write enable
//   waddr/wdata write index / data (written on rising clk)
//   raddr       read index
//   rdata       mem[raddr], combinational from the storage registers
module ras_spec_stack_array #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int DATA_W  = 38
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [ENTRIES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ras_spec_stack.sv
// ras_spec_stack
//   Speculative circular return address stack for the fetch predictor.
//   Pushes on link actions, pops on returns, performs pop-then-push
//   atomically when both arrive together (RET_L), saturates its occupancy
//   count, and restores (head, count) in one cycle on a redirect.
//   Popping an empty stack still moves head so that a mispredicted
//   underflow can be undone exactly by restoring the checkpoint.
//
// Optional build macro: RAS_OVERFLOW_STATS_EN adds a 16-bit saturating
//   overflow_count output, cleared only by reset.
//
// Ports:
//   CLK, RST       clock, asynchronous active-high reset
//   link_valid     push link_pc
//   link_pc        return address to push
//   ret_valid      pop
//   ret_pc         entry at head (registered state)
//   ret_empty      occupancy is zero
//   ras_head       current head index (for snapshot)
//   ras_count      current occupancy 0..RAS_ENTRIES (for snapshot)
//   restore_valid  restore head/count, overrides link/ret
//   restore_head   head to restore
//   restore_count  count to restore, clamped to RAS_ENTRIES
//   overflow       pulse: previous cycle's push overwrote a live entry
//   overflow_count (RAS_OVERFLOW_STATS_EN) number of overflowing pushes
//
// Handshake: no back-pressure. link_valid/ret_valid/restore_valid are
//   single-cycle commands sampled on every rising CLK edge; every command
//   is accepted in the cycle it is presented and results are visible on
//   the outputs right after that edge.
module ras_spec_stack #(
  parameter int RAS_ENTRIES     = 16,
  parameter int LOG_RAS_ENTRIES = $clog2(RAS_ENTRIES),
  parameter int PC_WIDTH        = 38
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       link_valid,
  input  logic [PC_WIDTH-1:0]        link_pc,
  input  logic                       ret_valid,
  output logic [PC_WIDTH-1:0]        ret_pc,
  output logic                       ret_empty,
  output logic [LOG_RAS_ENTRIES-1:0] ras_head,
  output logic [LOG_RAS_ENTRIES:0]   ras_count,
  input  logic                       restore_valid,
  input  logic [LOG_RAS_ENTRIES-1:0] restore_head,
  input  logic [LOG_RAS_ENTRIES:0]   restore_count,
  output logic                       overflow
`ifdef RAS_OVERFLOW_STATS_EN
  ,
  output logic [15:0]                overflow_count
`endif
);

  import ras_spec_stack_pkg::*;

  localparam int IDX_W = LOG_RAS_ENTRIES;
  localparam int CNT_W = LOG_RAS_ENTRIES + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_ENTRIES);

  logic [IDX_W-1:0] head_q, head_nxt;
  logic [CNT_W-1:0] count_q, count_nxt;
  logic             ovf_q, ovf_nxt;

  logic             arr_we;
  logic [IDX_W-1:0] arr_waddr;
  logic [IDX_W-1:0] head_inc;
  logic [IDX_W-1:0] head_dec;
  ras_op_e          op;

  // Index arithmetic wraps by truncation to IDX_W bits.
  assign head_inc = head_q + IDX_W'(1);
  assign head_dec = head_q - IDX_W'(1);
  assign op       = ras_op_decode(restore_valid, link_valid, ret_valid);

  always_comb begin
    head_nxt  = head_q;
    count_nxt = count_q;
    ovf_nxt   = 1'b0;
    arr_we    = 1'b0;
    arr_waddr = head_inc;
    case (op)
      OP_RESTORE: begin
        head_nxt  = restore_head;
        count_nxt = (restore_count > FULL) ? FULL : restore_count;
      end
      OP_PUSH_POP: begin
        // Pop then push lands on the same slot: overwrite in place.
        arr_we    = 1'b1;
        arr_waddr = head_q;
        count_nxt = (count_q == '0) ? CNT_W'(1) : count_q;
      end
      OP_PUSH: begin
        arr_we    = 1'b1;
        arr_waddr = head_inc;
        head_nxt  = head_inc;
        count_nxt = (count_q == FULL) ? FULL : count_q + CNT_W'(1);
        ovf_nxt   = (count_q == FULL);
      end
      OP_POP: begin
        head_nxt  = head_dec;
        count_nxt = (count_q == '0) ? '0 : count_q - CNT_W'(1);
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_nxt;
      count_q <= count_nxt;
      ovf_q   <= ovf_nxt;
    end
  end

  ras_spec_stack_array #(
    .ENTRIES (RAS_ENTRIES),
    .IDX_W   (IDX_W),
    .DATA_W  (PC_WIDTH)
  ) u_array (
    .clk   (CLK),
    .rst   (RST),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (link_pc),
    .raddr (head_q),
    .rdata (ret_pc)
  );

`ifdef RAS_OVERFLOW_STATS_EN
  logic [15:0] ovf_cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ovf_cnt_q <= '0;
    end else if (ovf_nxt && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_q <= ovf_cnt_q + 16'd1;
    end
  end

  assign overflow_count = ovf_cnt_q;
`endif

  assign ras_head  = head_q;
  assign ras_count = count_q;
  assign ret_empty = (count_q == '0);
  assign overflow  = ovf_q;

endmodule
